// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_t   : FSM encoding (IDLE=0, RUN=1, DONE=2), 2 bits wide.
//   cfg_legal : returns 1 when DIGIT divides WIDTH and 1 <= DIGIT <= WIDTH.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit cfg_legal(int width, int digit);
        return (digit >= 1) && (digit <= width) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle of the serial adder.
//   a, b, sub, in_valid     : operand side, driven by the producer
//   in_ready                : operand side, driven by the adder
//   s, c, v, out_valid      : result side, driven by the adder
//   out_ready               : result side, driven by the consumer
// Modports: master = producer/consumer, slave = the adder.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output a, b, sub, in_valid, out_ready,
        input  in_ready, s, c, v, out_valid
    );

    modport slave (
        input  a, b, sub, in_valid, out_ready,
        output in_ready, s, c, v, out_valid
    );
endinterface

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder, one digit of the serial datapath.
//   x, y     : digit operands
//   cin      : carry into bit 0
//   sum      : digit sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (used for signed overflow)
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);
    logic [DIGIT:0] carry;

    assign carry[0] = cin;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign sum[gi]      = x[gi] ^ y[gi] ^ carry[gi];
        assign carry[gi+1]  = (x[gi] & y[gi]) | (x[gi] & carry[gi]) | (y[gi] & carry[gi]);
    end

    assign cout     = carry[DIGIT];
    assign c_msb_in = carry[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor with valid/ready handshakes.
// Processes DIGIT bits per cycle, so a result takes N = WIDTH/DIGIT RUN edges.
//   clk : clock, all state on rising edge
//   rst : synchronous active-high reset
//   bus : serial_adder_if slave (a, b, sub, in_valid, in_ready,
//         s, c, v, out_valid, out_ready)
// Subtraction is done as A + ~B + 1: B is inverted at acceptance and the
// carry register is seeded with sub.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    serial_adder_if.slave   bus
);
    if (!cfg_legal(WIDTH, DIGIT)) begin : g_cfg_check
        $error("serial_adder: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    state_t           state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic             carry_reg;
    logic             c_reg;
    logic             v_reg;
    logic             out_valid_reg;
    logic [CW-1:0]    cnt_reg;

    logic             in_ready;
    logic             accept;
    logic [DIGIT-1:0] digit_sum;
    logic             digit_cout;
    logic             digit_c_msb_in;
    logic [WIDTH-1:0] sum_wide;
    logic             last_digit;

    // Depends only on state, reset and out_ready -- never on in_valid.
    assign in_ready   = !rst && ((state_reg == IDLE) ||
                                 ((state_reg == DONE) && bus.out_ready));
    assign accept     = bus.in_valid && in_ready;
    assign last_digit = (cnt_reg == CW'(N - 1));
    assign sum_wide   = WIDTH'(digit_sum);

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x        (a_reg[DIGIT-1:0]),
        .y        (b_reg[DIGIT-1:0]),
        .cin      (carry_reg),
        .sum      (digit_sum),
        .cout     (digit_cout),
        .c_msb_in (digit_c_msb_in)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            s_reg         <= '0;
            carry_reg     <= 1'b0;
            c_reg         <= 1'b0;
            v_reg         <= 1'b0;
            out_valid_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // Result digits enter at the MSB so the first (least
                    // significant) digit ends at bit 0 after N shifts.
                    s_reg     <= (s_reg >> DIGIT) | (sum_wide << (WIDTH - DIGIT));
                    a_reg     <= a_reg >> DIGIT;
                    b_reg     <= b_reg >> DIGIT;
                    carry_reg <= digit_cout;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_digit) begin
                        c_reg         <= digit_cout;
                        v_reg         <= digit_c_msb_in ^ digit_cout;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= accept ? RUN : IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // Acceptance only happens in IDLE or DONE, never alongside RUN updates.
            if (accept) begin
                a_reg     <= bus.a;
                b_reg     <= bus.b ^ {WIDTH{bus.sub}};
                carry_reg <= bus.sub;
                cnt_reg   <= '0;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.s         = s_reg;
    assign bus.c         = c_reg;
    assign bus.v         = v_reg;
    assign bus.out_valid = out_valid_reg;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench: three serial_adder instances (WIDTH=8, DIGIT=1/2/8)
// driven from a shared clock, directed vector table plus hand sequences
// for reset, back-pressure, back-to-back and in_valid-during-RUN cases.
module tb_serial_adder;
    localparam int NU = 3;
    localparam int DG [NU] = '{1, 2, 8};

    logic       clk;
    logic       rst_t  [NU];
    logic [7:0] a_t    [NU];
    logic [7:0] b_t    [NU];
    logic       sub_t  [NU];
    logic       iv_t   [NU];
    logic       or_t   [NU];
    logic       ir_o   [NU];
    logic [7:0] s_o    [NU];
    logic       c_o    [NU];
    logic       v_o    [NU];
    logic       ov_o   [NU];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NU; gi++) begin : g_unit
        serial_adder_if #(.WIDTH(8)) bus ();
        assign bus.a         = a_t[gi];
        assign bus.b         = b_t[gi];
        assign bus.sub       = sub_t[gi];
        assign bus.in_valid  = iv_t[gi];
        assign bus.out_ready = or_t[gi];
        assign ir_o[gi]      = bus.in_ready;
        assign s_o[gi]       = bus.s;
        assign c_o[gi]       = bus.c;
        assign v_o[gi]       = bus.v;
        assign ov_o[gi]      = bus.out_valid;

        serial_adder #(.WIDTH(8), .DIGIT(DG[gi])) dut (
            .clk (clk),
            .rst (rst_t[gi]),
            .bus (bus.slave)
        );
    end

    typedef struct {
        int         unit;
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       v;
        int         lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Call at a negedge; returns at the negedge after the acceptance edge.
    task automatic accept(input int k, input logic [7:0] a, input logic [7:0] b, input logic sub);
        int n = 0;
        while (!ir_o[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d accept_ready", k), 32'(ir_o[k]), 32'd1);
        a_t[k] = a; b_t[k] = b; sub_t[k] = sub; iv_t[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv_t[k] = 1'b0;
    endtask

    // Waits for out_valid, checks latency and result, then consumes it.
    task automatic collect(input int k, input int lat, input logic [7:0] es,
                           input logic ec, input logic ev, input string nm, input bit junk);
        int n = 0;
        while (!ov_o[k] && n < 40) begin
            if (junk) begin
                check($sformatf("%s ready_in_run", nm), 32'(ir_o[k]), 32'd0);
                iv_t[k] = (n % 2 == 0); a_t[k] = 8'hAA; b_t[k] = 8'h11; sub_t[k] = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        iv_t[k] = 1'b0;
        check($sformatf("%s latency", nm), 32'(n), 32'(lat));
        check($sformatf("%s s", nm), 32'(s_o[k]), 32'(es));
        check($sformatf("%s c", nm), 32'(c_o[k]), 32'(ec));
        check($sformatf("%s v", nm), 32'(v_o[k]), 32'(ev));
        or_t[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        or_t[k] = 1'b0;
        check($sformatf("%s ov_drop", nm), 32'(ov_o[k]), 32'd0);
    endtask

    initial begin
        int quiet;
        vecs[0] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 8};
        vecs[1] = '{0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 8};
        vecs[2] = '{0, 8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0, 8};
        vecs[3] = '{0, 8'h80, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0, 8};
        vecs[4] = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 4};
        vecs[5] = '{1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 4};
        vecs[6] = '{1, 8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0, 4};
        vecs[7] = '{2, 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1};
        vecs[8] = '{2, 8'h64, 8'h64, 1'b0, 8'hC8, 1'b0, 1'b1, 1};

        for (int k = 0; k < NU; k++) begin
            rst_t[k] = 1'b1; a_t[k] = '0; b_t[k] = '0; sub_t[k] = 1'b0;
            iv_t[k] = 1'b0; or_t[k] = 1'b0;
        end
        repeat (3) @(negedge clk);

        // Reset state
        for (int k = 0; k < NU; k++) begin
            check($sformatf("u%0d ready_in_rst", k), 32'(ir_o[k]), 32'd0);
            check($sformatf("u%0d ov_rst", k), 32'(ov_o[k]), 32'd0);
            check($sformatf("u%0d scv_rst", k), {22'd0, s_o[k], c_o[k], v_o[k]}, 32'd0);
            rst_t[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < NU; k++)
            check($sformatf("u%0d ready_after_rst", k), 32'(ir_o[k]), 32'd1);
        @(negedge clk);

        // Vector table
        for (int i = 0; i < 9; i++) begin
            accept(vecs[i].unit, vecs[i].a, vecs[i].b, vecs[i].sub);
            collect(vecs[i].unit, vecs[i].lat, vecs[i].s, vecs[i].c, vecs[i].v,
                    $sformatf("vec%0d", i), 1'b0);
        end

        // Back-pressure then zero-bubble back-to-back (DIGIT=2)
        accept(1, 8'h7F, 8'h01, 1'b0);
        quiet = 0;
        while (!ov_o[1] && quiet < 40) begin
            @(negedge clk);
            quiet++;
        end
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d hold", i), {20'd0, ov_o[1], ir_o[1], s_o[1], c_o[1], v_o[1]},
                  {20'd0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
            @(negedge clk);
        end
        or_t[1] = 1'b1; iv_t[1] = 1'b1; a_t[1] = 8'h10; b_t[1] = 8'h01; sub_t[1] = 1'b0;
        #1;
        check("b2b ready", 32'(ir_o[1]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        or_t[1] = 1'b0; iv_t[1] = 1'b0;
        check("b2b consumed", 32'(ov_o[1]), 32'd0);
        check("b2b busy", 32'(ir_o[1]), 32'd0);
        collect(1, 4, 8'h11, 1'b0, 1'b0, "b2b", 1'b0);

        // Reset on the 3rd RUN edge (DIGIT=1)
        accept(0, 8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_t[0] = 1'b1;
        #1;
        check("midrst ready", 32'(ir_o[0]), 32'd0);
        @(negedge clk);
        rst_t[0] = 1'b0;
        check("midrst ov", 32'(ov_o[0]), 32'd0);
        check("midrst s", 32'(s_o[0]), 32'd0);
        #1;
        check("midrst idle", 32'(ir_o[0]), 32'd1);
        quiet = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov_o[0]) quiet++;
        end
        check("midrst no_stale", 32'(quiet), 32'd0);
        accept(0, 8'h10, 8'h20, 1'b0);
        collect(0, 8, 8'h30, 1'b0, 1'b0, "midrst fresh", 1'b0);

        // in_valid pulses during RUN are ignored (DIGIT=1)
        accept(0, 8'h01, 8'h02, 1'b0);
        collect(0, 8, 8'h03, 1'b0, 1'b0, "ivrun", 1'b1);
        quiet = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov_o[0]) quiet++;
        end
        check("ivrun no_second", 32'(quiet), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
